// File: rtl/param_instr_decoder.sv
// Registered instruction decode stage: valid/ready input, one-deep output
// bundle, conditional-branch evaluation, flag-hazard stall and branch
// delay-slot discard.
//
// Handshake: a word transfers on any rising edge where in_valid & in_ready;
// a bundle transfers on any rising edge where out_valid & out_ready. The
// bundle is held stable while out_valid & !out_ready, and a consume plus a
// new accept on the same edge replaces the bundle without a bubble.
module param_instr_decoder #(
  parameter int INSTR_W      = 16,
  parameter int OPCODE_W     = 6,
  parameter int NUM_ACC      = 2,
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 9,
  parameter int HAZARD_STALL = 1,
  parameter int FLUSH_SLOTS  = 1,
  localparam int ACC_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [NUM_ACC-1:0] flag_z,
  input  logic [NUM_ACC-1:0] flag_c,
  input  logic [NUM_ACC-1:0] flag_n,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   o_acc_sel,
  output logic [3:0]         o_alu_op,
  output logic               o_write_acc,
  output logic               o_mem_read,
  output logic               o_mem_write,
  output logic [DATA_W-1:0]  o_imm,
  output logic [ADDR_W-1:0]  o_addr,
  output logic               o_branch_taken,
  output logic               o_illegal,
  output logic [1:0]         dbg_state
);
  localparam int OPND_W = INSTR_W - OPCODE_W - ACC_W;
  localparam int HCW    = (HAZARD_STALL > 0) ? $clog2(HAZARD_STALL + 1) : 1;
  localparam int FCW    = (FLUSH_SLOTS > 0) ? $clog2(FLUSH_SLOTS + 1) : 1;

  // RUN: normal; STALL: a hazard window is open on haz_acc;
  // FLUSH: delay-slot instructions are being discarded.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic [ACC_W-1:0]  acc_sel;
    logic [3:0]        alu_op;
    logic              write_acc;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] addr;
    logic              branch_taken;
    logic              illegal;
  } bundle_t;

  state_e             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  bundle_t            bundle_q, bundle_d;
  logic [HCW-1:0]     haz_cnt_q, haz_cnt_d;
  logic [ACC_W-1:0]   haz_acc_q, haz_acc_d;
  logic [FCW-1:0]     flush_cnt_q, flush_cnt_d;

  logic [OPCODE_W-1:0] opcode;
  logic [ACC_W-1:0]    acc;
  logic [OPND_W-1:0]   operand;
  logic [1:0]          cls;
  logic [3:0]          sub;
  logic                mid_nz, acc_ok, f_z, f_c, f_n;
  bundle_t             dec;
  logic                dec_cond;
  logic                flushing, stall, accept, issue;

  // Field extraction and decode of the word currently on in_instr.
  always_comb begin
    opcode   = in_instr[INSTR_W-1 -: OPCODE_W];
    acc      = in_instr[INSTR_W-OPCODE_W-1 -: ACC_W];
    operand  = in_instr[OPND_W-1:0];
    cls      = opcode[OPCODE_W-1 -: 2];
    sub      = opcode[3:0];
    mid_nz   = 1'b0;
    for (int i = 4; i < OPCODE_W - 2; i++) mid_nz = mid_nz | opcode[i];
    acc_ok   = 1'b0;
    f_z      = 1'b0;
    f_c      = 1'b0;
    f_n      = 1'b0;
    for (int i = 0; i < NUM_ACC; i++) begin
      if (acc == ACC_W'(i)) begin
        acc_ok = 1'b1;
        f_z    = flag_z[i];
        f_c    = flag_c[i];
        f_n    = flag_n[i];
      end
    end
    dec          = '0;
    dec.acc_sel  = acc;
    dec.imm      = operand[DATA_W-1:0];
    dec.addr     = operand[ADDR_W-1:0];
    dec_cond     = 1'b0;
    if (mid_nz || !acc_ok) begin
      dec.illegal = 1'b1;
    end else begin
      case (cls)
        2'b00: begin
          dec.alu_op    = sub;
          dec.write_acc = 1'b1;
        end
        2'b01: begin
          case (sub)
            4'd0: begin
              dec.mem_read  = 1'b1;
              dec.write_acc = 1'b1;
            end
            4'd1:    dec.mem_write = 1'b1;
            default: dec.illegal   = 1'b1;
          endcase
        end
        2'b10: begin
          case (sub)
            4'd0:    dec.branch_taken = 1'b1;
            4'd1:    dec.branch_taken = f_z;
            4'd2:    dec.branch_taken = !f_z;
            4'd3:    dec.branch_taken = f_c;
            4'd4:    dec.branch_taken = !f_c;
            4'd5:    dec.branch_taken = f_n;
            4'd6:    dec.branch_taken = !f_n;
            default: dec.illegal      = 1'b1;
          endcase
          dec_cond = (sub >= 4'd1) && (sub <= 4'd6);
        end
        default: begin
          if (sub != 4'd0) dec.illegal = 1'b1;
        end
      endcase
    end
  end

  // Handshake, hazard/flush counters and next-state selection.
  always_comb begin
    flushing    = (flush_cnt_q != '0);
    stall       = in_valid && dec_cond && (acc == haz_acc_q) && (haz_cnt_q != '0);
    in_ready    = (!out_valid_q || out_ready) && !stall && reset_n;
    accept      = in_valid && in_ready;
    issue       = accept && !flushing;

    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    if (issue) begin
      out_valid_d = 1'b1;
      bundle_d    = dec;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    haz_cnt_d = haz_cnt_q;
    haz_acc_d = haz_acc_q;
    if (haz_cnt_q != '0) haz_cnt_d = haz_cnt_q - 1'b1;
    if (issue && dec.write_acc) begin
      haz_cnt_d = HCW'(HAZARD_STALL);
      haz_acc_d = acc;
    end

    flush_cnt_d = flush_cnt_q;
    if (accept && flushing) flush_cnt_d = flush_cnt_q - 1'b1;
    else if (issue && dec.branch_taken) flush_cnt_d = FCW'(FLUSH_SLOTS);

    state_d = ST_RUN;
    if (flush_cnt_d != '0) state_d = ST_FLUSH;
    else if (haz_cnt_d != '0) state_d = ST_STALL;
  end

  // State and bundle registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_RUN;
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
      haz_cnt_q   <= '0;
      haz_acc_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
      haz_cnt_q   <= haz_cnt_d;
      haz_acc_q   <= haz_acc_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign o_acc_sel      = bundle_q.acc_sel;
  assign o_alu_op       = bundle_q.alu_op;
  assign o_write_acc    = bundle_q.write_acc;
  assign o_mem_read     = bundle_q.mem_read;
  assign o_mem_write    = bundle_q.mem_write;
  assign o_imm          = bundle_q.imm;
  assign o_addr         = bundle_q.addr;
  assign o_branch_taken = bundle_q.branch_taken;
  assign o_illegal      = bundle_q.illegal;
  assign dbg_state      = state_q;
endmodule

// File: tb/tb_param_instr_decoder.sv
// Bench for param_instr_decoder with default parameters: directed scenarios
// plus a randomized run, all checked against a cycle-level reference model.
module tb_param_instr_decoder;
  localparam int INSTR_W = 16, OPCODE_W = 6, NUM_ACC = 2, ACC_W = 1, OPND_W = 9;
  localparam int HAZARD_STALL = 1, FLUSH_SLOTS = 1;

  logic        clk = 1'b0;
  logic        reset_n, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_instr;
  logic [1:0]  flag_z, flag_c, flag_n;
  logic [0:0]  o_acc_sel;
  logic [3:0]  o_alu_op;
  logic        o_write_acc, o_mem_read, o_mem_write, o_branch_taken, o_illegal;
  logic [7:0]  o_imm;
  logic [8:0]  o_addr;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  param_instr_decoder dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n),
    .out_valid(out_valid), .out_ready(out_ready), .o_acc_sel(o_acc_sel),
    .o_alu_op(o_alu_op), .o_write_acc(o_write_acc), .o_mem_read(o_mem_read),
    .o_mem_write(o_mem_write), .o_imm(o_imm), .o_addr(o_addr),
    .o_branch_taken(o_branch_taken), .o_illegal(o_illegal), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic [0:0] acc;
    logic [3:0] alu;
    logic       wr_acc, mrd, mwr;
    logic [7:0] imm;
    logic [8:0] addr;
    logic       taken, ill;
  } obs_t;

  function automatic obs_t dut_obs();
    return {out_valid, o_acc_sel, o_alu_op, o_write_acc, o_mem_read, o_mem_write,
            o_imm, o_addr, o_branch_taken, o_illegal};
  endfunction

  function automatic obs_t mk(input logic v, input logic [0:0] a, input logic [3:0] alu,
                              input logic wa, input logic mr, input logic mw,
                              input logic [7:0] imm, input logic [8:0] addr,
                              input logic tk, input logic il);
    return {v, a, alu, wa, mr, mw, imm, addr, tk, il};
  endfunction

  // ---------------- reference model ----------------
  function automatic int acc_of(input logic [15:0] w);
    int unsigned wi = w;
    return int'((wi >> OPND_W) % (1 << ACC_W));
  endfunction

  function automatic bit ref_cond(input logic [15:0] w);
    int unsigned wi = w;
    int opc = int'(wi >> (INSTR_W - OPCODE_W));
    int cls = opc >> (OPCODE_W - 2);
    int sub = opc % 16;
    int mid = (opc >> 4) % (1 << (OPCODE_W - 6));
    return (mid == 0) && (acc_of(w) < NUM_ACC) && (cls == 2) && (sub >= 1) && (sub <= 6);
  endfunction

  function automatic obs_t ref_decode(input logic [15:0] w, input logic [1:0] z, c, n);
    obs_t r;
    int unsigned wi = w;
    int opc  = int'(wi >> (INSTR_W - OPCODE_W));
    int acc  = acc_of(w);
    int opnd = int'(wi % (1 << OPND_W));
    int cls  = opc >> (OPCODE_W - 2);
    int sub  = opc % 16;
    int mid  = (opc >> 4) % (1 << (OPCODE_W - 6));
    bit legal;
    logic [1:0] fv;
    r = '0;
    r.valid = 1'b1;
    r.acc   = 1'(acc);
    r.imm   = 8'(opnd % 256);
    r.addr  = 9'(opnd % 512);
    legal   = (mid == 0) && (acc < NUM_ACC);
    if (legal) begin
      if (cls == 0) begin
        r.alu = 4'(sub); r.wr_acc = 1'b1;
      end else if (cls == 1) begin
        if (sub == 0) begin r.mrd = 1'b1; r.wr_acc = 1'b1; end
        else if (sub == 1) r.mwr = 1'b1;
        else legal = 0;
      end else if (cls == 2) begin
        if (sub == 0) r.taken = 1'b1;
        else if (sub <= 6) begin
          fv = ((sub - 1) / 2 == 0) ? z : (((sub - 1) / 2 == 1) ? c : n);
          r.taken = (((sub - 1) % 2) == 0) ? fv[acc] : !fv[acc];
        end else legal = 0;
      end else begin
        if (sub != 0) legal = 0;
      end
    end
    if (!legal) begin
      r.alu = '0; r.wr_acc = 0; r.mrd = 0; r.mwr = 0; r.taken = 0;
    end
    r.ill = !legal;
    return r;
  endfunction

  obs_t m_out = '0;
  int   m_edges = 0;
  int   m_wr_edge = -1000;
  int   m_wr_acc = 0;
  int   m_flush_left = 0;

  // Expected in_ready for the inputs currently applied.
  function automatic bit m_ready();
    bit stall;
    if (reset_n !== 1'b1) return 1'b0;
    stall = in_valid && ref_cond(in_instr) && (acc_of(in_instr) == m_wr_acc) &&
            ((m_edges - m_wr_edge) < HAZARD_STALL);
    return (!m_out.valid || out_ready) && !stall;
  endfunction

  // Advance the model across one rising edge.
  task automatic m_update();
    bit   acc_ok;
    obs_t d;
    if (!reset_n) begin
      m_out = '0; m_wr_edge = -1000; m_wr_acc = 0; m_flush_left = 0;
    end else begin
      acc_ok = in_valid && m_ready();
      if (acc_ok && m_flush_left == 0) begin
        d = ref_decode(in_instr, flag_z, flag_c, flag_n);
        m_out = d;
        if (d.wr_acc) begin m_wr_edge = m_edges + 1; m_wr_acc = acc_of(in_instr); end
        if (d.taken) m_flush_left = FLUSH_SLOTS;
      end else begin
        if (out_ready) m_out.valid = 1'b0;
        if (acc_ok && m_flush_left > 0) m_flush_left--;
      end
    end
    m_edges++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [15:0] w, input logic [1:0] z, c, n,
                       input logic ordy);
    in_valid = v; in_instr = w; flag_z = z; flag_c = c; flag_n = n; out_ready = ordy;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(1'b0, 16'h0, 2'b00, 2'b00, 2'b00, 1'b1);
    step();
    step();
    reset_n = 1'b1;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b1, 16'h0805, 2'b11, 2'b11, 2'b11, 1'b1);
    step();
    step();
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_ready: in_ready=%0b required 0", in_ready);
    end
    n_vec++;
    if (dut_obs() !== obs_t'('0)) begin
      n_err++; $display("FAIL reset_outputs: got %h required 0", dut_obs());
    end
    reset_n = 1'b1;
    drive(1'b0, 16'h0, 2'b00, 2'b00, 2'b00, 1'b1);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_release_ready: in_ready=%0b required 1", in_ready);
    end
  endtask

  task automatic test_alu();
    do_reset();
    drive(1'b1, 16'b000010_0_000000101, 2'b00, 2'b00, 2'b00, 1'b1);
    step();
    n_vec++;
    if (dut_obs() !== mk(1, 0, 4'h2, 1, 0, 0, 8'h05, 9'h005, 0, 0)) begin
      n_err++; $display("FAIL alu_bundle: got %h required %h", dut_obs(),
                        mk(1, 0, 4'h2, 1, 0, 0, 8'h05, 9'h005, 0, 0));
    end
  endtask

  task automatic test_hazard();
    do_reset();
    drive(1'b1, {6'b010000, 1'b1, 9'h1FF}, 2'b00, 2'b00, 2'b00, 1'b1);
    step();
    n_vec++;
    if (dut_obs() !== mk(1, 1, 0, 1, 1, 0, 8'hFF, 9'h1FF, 0, 0)) begin
      n_err++; $display("FAIL lda_bundle: got %h required %h", dut_obs(),
                        mk(1, 1, 0, 1, 1, 0, 8'hFF, 9'h1FF, 0, 0));
    end
    drive(1'b1, {6'b100001, 1'b1, 9'h010}, 2'b10, 2'b00, 2'b00, 1'b1);
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL hazard_stall: in_ready=%0b required 0", in_ready);
    end
    step();
    #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL hazard_release: in_ready=%0b out_valid=%0b required 1/0",
                        in_ready, out_valid);
    end
    step();
    n_vec++;
    if (dut_obs() !== mk(1, 1, 0, 0, 0, 0, 8'h10, 9'h010, 1, 0)) begin
      n_err++; $display("FAIL bz_taken: got %h required %h", dut_obs(),
                        mk(1, 1, 0, 0, 0, 0, 8'h10, 9'h010, 1, 0));
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, {6'b100000, 1'b0, 9'h155}, 2'b00, 2'b00, 2'b00, 1'b1);
    step();
    n_vec++;
    if (dut_obs() !== mk(1, 0, 0, 0, 0, 0, 8'h55, 9'h155, 1, 0)) begin
      n_err++; $display("FAIL jmp_bundle: got %h required %h", dut_obs(),
                        mk(1, 0, 0, 0, 0, 0, 8'h55, 9'h155, 1, 0));
    end
    drive(1'b1, {6'b010001, 1'b0, 9'h0F0}, 2'b00, 2'b00, 2'b00, 1'b1);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL flush_ready: in_ready=%0b required 1", in_ready);
    end
    step();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_discard: out_valid=%0b required 0", out_valid);
    end
    drive(1'b1, {6'b110000, 1'b0, 9'h000}, 2'b00, 2'b00, 2'b00, 1'b1);
    step();
    n_vec++;
    if (dut_obs() !== mk(1, 0, 0, 0, 0, 0, 8'h00, 9'h000, 0, 0)) begin
      n_err++; $display("FAIL nop_after_flush: got %h required %h", dut_obs(),
                        mk(1, 0, 0, 0, 0, 0, 8'h00, 9'h000, 0, 0));
    end
    // A taken branch inside the window is dropped and does not re-arm it.
    drive(1'b1, {6'b100000, 1'b1, 9'h0A0}, 2'b00, 2'b00, 2'b00, 1'b1);
    step();
    drive(1'b1, {6'b100000, 1'b0, 9'h0B0}, 2'b00, 2'b00, 2'b00, 1'b1);
    step();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL flushed_branch: out_valid=%0b required 0", out_valid);
    end
    drive(1'b1, {6'b000001, 1'b1, 9'h0C3}, 2'b00, 2'b00, 2'b00, 1'b1);
    step();
    n_vec++;
    if (dut_obs() !== mk(1, 1, 4'h1, 1, 0, 0, 8'hC3, 9'h0C3, 0, 0)) begin
      n_err++; $display("FAIL after_flushed_branch: got %h required %h", dut_obs(),
                        mk(1, 1, 4'h1, 1, 0, 0, 8'hC3, 9'h0C3, 0, 0));
    end
  endtask

  task automatic test_back_to_back();
    obs_t exp_a, exp_b;
    exp_a = mk(1, 1, 4'h3, 1, 0, 0, 8'hAA, 9'h0AA, 0, 0);
    exp_b = mk(1, 0, 4'h5, 1, 0, 0, 8'h33, 9'h033, 0, 0);
    do_reset();
    drive(1'b1, {6'b000011, 1'b1, 9'h0AA}, 2'b00, 2'b00, 2'b00, 1'b1);
    step();
    drive(1'b1, {6'b000101, 1'b0, 9'h033}, 2'b00, 2'b00, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (in_ready !== 1'b0 || dut_obs() !== exp_a) begin
        n_err++; $display("FAIL backpressure_hold[%0d]: in_ready=%0b bundle=%h required 0/%h",
                          i, in_ready, dut_obs(), exp_a);
      end
      step();
    end
    drive(1'b1, {6'b000101, 1'b0, 9'h033}, 2'b00, 2'b00, 2'b00, 1'b1);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL backpressure_release: in_ready=%0b required 1", in_ready);
    end
    step();
    n_vec++;
    if (dut_obs() !== exp_b) begin
      n_err++; $display("FAIL no_bubble: got %h required %h", dut_obs(), exp_b);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    drive(1'b1, {6'b011111, 1'b0, 9'h123}, 2'b11, 2'b11, 2'b11, 1'b1);
    step();
    n_vec++;
    if (dut_obs() !== mk(1, 0, 0, 0, 0, 0, 8'h23, 9'h123, 0, 1)) begin
      n_err++; $display("FAIL illegal_mem: got %h required %h", dut_obs(),
                        mk(1, 0, 0, 0, 0, 0, 8'h23, 9'h123, 0, 1));
    end
    drive(1'b1, {6'b110001, 1'b1, 9'h045}, 2'b11, 2'b11, 2'b11, 1'b1);
    step();
    n_vec++;
    if (dut_obs() !== mk(1, 1, 0, 0, 0, 0, 8'h45, 9'h045, 0, 1)) begin
      n_err++; $display("FAIL illegal_c3: got %h required %h", dut_obs(),
                        mk(1, 1, 0, 0, 0, 0, 8'h45, 9'h045, 0, 1));
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    // Reset while a branch is held on a hazard.
    drive(1'b1, {6'b010000, 1'b1, 9'h011}, 2'b00, 2'b00, 2'b00, 1'b1);
    step();
    drive(1'b1, {6'b100001, 1'b1, 9'h020}, 2'b00, 2'b00, 2'b00, 1'b1);
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL stall_reset_ready: in_ready=%0b required 0", in_ready);
    end
    step();
    n_vec++;
    if (dut_obs() !== obs_t'('0)) begin
      n_err++; $display("FAIL stall_reset_outputs: got %h required 0", dut_obs());
    end
    reset_n = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL bz_after_reset_ready: in_ready=%0b required 1", in_ready);
    end
    step();
    n_vec++;
    if (dut_obs() !== mk(1, 1, 0, 0, 0, 0, 8'h20, 9'h020, 0, 0)) begin
      n_err++; $display("FAIL bz_after_reset: got %h required %h", dut_obs(),
                        mk(1, 1, 0, 0, 0, 0, 8'h20, 9'h020, 0, 0));
    end
    // Reset inside the delay-slot window.
    drive(1'b1, {6'b100000, 1'b0, 9'h077}, 2'b00, 2'b00, 2'b00, 1'b1);
    step();
    reset_n = 1'b0;
    drive(1'b0, 16'h0, 2'b00, 2'b00, 2'b00, 1'b1);
    step();
    n_vec++;
    if (dut_obs() !== obs_t'('0)) begin
      n_err++; $display("FAIL flush_reset_outputs: got %h required 0", dut_obs());
    end
    reset_n = 1'b1;
    drive(1'b1, {6'b000111, 1'b0, 9'h0E1}, 2'b00, 2'b00, 2'b00, 1'b1);
    step();
    n_vec++;
    if (dut_obs() !== mk(1, 0, 4'h7, 1, 0, 0, 8'hE1, 9'h0E1, 0, 0)) begin
      n_err++; $display("FAIL not_flushed_after_reset: got %h required %h", dut_obs(),
                        mk(1, 0, 4'h7, 1, 0, 0, 8'hE1, 9'h0E1, 0, 0));
    end
  endtask

  function automatic logic [15:0] rand_instr();
    int cls, sub;
    logic [15:0] w;
    if ($urandom_range(0, 9) == 0) begin
      w = 16'($urandom);
      return w;
    end
    cls = $urandom_range(0, 3);
    sub = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 6);
    w = {cls[1:0], sub[3:0], 1'($urandom_range(0, 1)), 9'($urandom)};
    return w;
  endfunction

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      reset_n = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
      drive(1'($urandom_range(0, 9) < 7), rand_instr(), 2'($urandom), 2'($urandom),
            2'($urandom), 1'($urandom_range(0, 3) != 0));
      n_vec++;
      if (in_ready !== m_ready()) begin
        n_err++; $display("FAIL rand_ready[%0d]: in_ready=%0b required %0b",
                          i, in_ready, m_ready());
      end
      step();
      n_vec++;
      if ((m_out.valid && dut_obs() !== m_out) || (!m_out.valid && out_valid !== 1'b0)) begin
        n_err++; $display("FAIL rand_bundle[%0d]: got %h required %h", i, dut_obs(), m_out);
      end
    end
    reset_n = 1'b1;
  endtask

  // Sequencer and final report.
  initial begin
    reset_n = 1'b0;
    in_valid = 1'b0; in_instr = '0; flag_z = '0; flag_c = '0; flag_n = '0; out_ready = 1'b1;
    test_reset();
    test_alu();
    test_hazard();
    test_flush();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
